// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } arb_state_e;

   localparam int MAX_HOLD_DEF = 4;
   localparam int HOLD_W       = 4;
   localparam int WIDX_LO      = 2;
   localparam int WIDX_W       = 6;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-port bundle; slave is the arbiter side, master the requester/memory side.
interface dmem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req0, req1;
   logic          we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wd0, wd1;
   logic          gnt0, gnt1;
   logic          rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rd,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
             mem_we, mem_addr, mem_wd
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wd0, wd1, mem_rd,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
             mem_we, mem_addr, mem_wd
   );
endinterface

// File: rtl/dmem_arbiter_rr_grant2.sv
// Combinational two-way picker: round-robin with a bounded hold for the current owner.
module rr_grant2
   import dmem_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic              req0,
   input  logic              req1,
   input  arb_state_e        state,
   input  logic              last,
   input  logic [HOLD_W-1:0] hold_cnt,
   output logic              gnt0,
   output logic              gnt1,
   output arb_state_e        next_state
);

   localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(MAX_HOLD - 1);

   always_comb begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      next_state = ST_IDLE;
      if (req0 && req1) begin
         case (state)
            ST_OWN0: if (hold_cnt >= HOLD_TOP) gnt1 = 1'b1; else gnt0 = 1'b1;
            ST_OWN1: if (hold_cnt >= HOLD_TOP) gnt0 = 1'b1; else gnt1 = 1'b1;
            default: if (last) gnt0 = 1'b1; else gnt1 = 1'b1;
         endcase
      end else begin
         gnt0 = req0;
         gnt1 = req1;
      end
      if (gnt0)      next_state = ST_OWN0;
      else if (gnt1) next_state = ST_OWN1;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the 64x32 data memory with registered read return.
// Optional grant/conflict counters enabled by DMEM_ARB_STATS_EN.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic                 clock,
   input  logic                 reset,
   dmem_arbiter_if.slave        bus
`ifdef DMEM_ARB_STATS_EN
   ,
   input  logic                 stat_clr,
   output logic [15:0]          stat_gnt0,
   output logic [15:0]          stat_gnt1,
   output logic [15:0]          stat_conflict
`endif
);

   localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(MAX_HOLD - 1);

   arb_state_e        state, next_state;
   logic              last, last_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic              gnt0, gnt1;
   logic [AW-1:0]     addr_sel;
   logic [DW-1:0]     wd_sel;
   logic              we_sel;

   rr_grant2 #(.MAX_HOLD(MAX_HOLD)) u_pick (
      .req0       (bus.req0),
      .req1       (bus.req1),
      .state      (state),
      .last       (last),
      .hold_cnt   (hold_cnt),
      .gnt0       (gnt0),
      .gnt1       (gnt1),
      .next_state (next_state)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         last     <= 1'b1;
         hold_cnt <= '0;
      end else begin
         state    <= next_state;
         last     <= last_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   // Repeat grant to the same owner extends the hold; anything else restarts it.
   always_comb begin
      hold_nxt = '0;
      last_nxt = last;
      if ((gnt0 && state == ST_OWN0) || (gnt1 && state == ST_OWN1))
         hold_nxt = (hold_cnt >= HOLD_TOP) ? hold_cnt : hold_cnt + 1'b1;
      if (gnt0 || gnt1)
         last_nxt = gnt1;
   end

   always_comb begin
      addr_sel = bus.addr0;
      wd_sel   = bus.wd0;
      we_sel   = gnt0 & bus.we0;
      if (gnt1) begin
         addr_sel = bus.addr1;
         wd_sel   = bus.wd1;
         we_sel   = bus.we1;
      end
   end

   assign bus.gnt0     = gnt0;
   assign bus.gnt1     = gnt1;
   assign bus.mem_addr = addr_sel;
   assign bus.mem_wd   = wd_sel;
   assign bus.mem_we   = we_sel;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.rvalid0 <= 1'b0;
         bus.rvalid1 <= 1'b0;
         bus.rdata0  <= '0;
         bus.rdata1  <= '0;
      end else begin
         bus.rvalid0 <= gnt0 & ~bus.we0;
         bus.rvalid1 <= gnt1 & ~bus.we1;
         if (gnt0 && !bus.we0) bus.rdata0 <= bus.mem_rd;
         if (gnt1 && !bus.we1) bus.rdata1 <= bus.mem_rd;
      end
   end

`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_gnt0     <= '0;
         stat_gnt1     <= '0;
         stat_conflict <= '0;
      end else if (stat_clr) begin
         stat_gnt0     <= '0;
         stat_gnt1     <= '0;
         stat_conflict <= '0;
      end else begin
         if (gnt0 && stat_gnt0 != 16'hFFFF) stat_gnt0 <= stat_gnt0 + 16'd1;
         if (gnt1 && stat_gnt1 != 16'hFFFF) stat_gnt1 <= stat_gnt1 + 16'd1;
         if (bus.req0 && bus.req1 && stat_conflict != 16'hFFFF)
            stat_conflict <= stat_conflict + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 64x32 memory on the port.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_errors;
   logic [31:0] ram [64];

   dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef DMEM_ARB_STATS_EN
   logic        stat_clr;
   logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

   dmem_arbiter #(.AW(32), .DW(32), .MAX_HOLD(4)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stat_clr      (stat_clr),
      .stat_gnt0     (stat_gnt0),
      .stat_gnt1     (stat_gnt1),
      .stat_conflict (stat_conflict)
`endif
   );

   assign bus.mem_rd = ram[bus.mem_addr[7:2]];
   always @(posedge clock) if (bus.mem_we) ram[bus.mem_addr[7:2]] <= bus.mem_wd;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   localparam logic [8:0] CONT_GNT0 = 9'b1_0000_1111;  // bit k = grant to 0 in cycle k
   int hold_exp [9] = '{0, 0, 1, 2, 3, 0, 1, 2, 3};

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < 64; i++) ram[i] = 32'h0;
      ram[2] = 32'h0000_00FF;
      ram[3] = 32'h0000_00A5;
      reset = 1'b1;
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = 32'h40; bus.addr1 = 32'h0; bus.wd0 = '0; bus.wd1 = '0;
`ifdef DMEM_ARB_STATS_EN
      stat_clr = 0;
`endif
      #2;
      chk("rst_rvalid0", 32'(bus.rvalid0), 0);
      chk("rst_rvalid1", 32'(bus.rvalid1), 0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("rst_rdata0", bus.rdata0, 0);
      chk("rst_rdata1", bus.rdata1, 0);
      chk("idle_gnt", 32'({bus.gnt0, bus.gnt1}), 0);
      chk("idle_we", 32'(bus.mem_we), 0);
      chk("idle_addr", bus.mem_addr, 32'h40);
      chk("rst_hold", 32'(u_dut.hold_cnt), 0);

      // alternating single requests, each granted immediately
      tick(); bus.req1 = 1; bus.addr1 = 32'h08;
      @(negedge clock);
      chk("alt1_gnt", 32'({bus.gnt0, bus.gnt1}), 32'b01);
      chk("alt1_addr", bus.mem_addr, 32'h08);
      tick(); bus.req1 = 0; bus.req0 = 1; bus.addr0 = 32'h08;
      @(negedge clock);
      chk("alt2_gnt", 32'({bus.gnt0, bus.gnt1}), 32'b10);
      chk("alt2_rvalid1", 32'(bus.rvalid1), 1);
      chk("alt2_rdata1", bus.rdata1, 32'hFF);
      chk("alt2_hold", 32'(u_dut.hold_cnt), 0);
      tick(); bus.req0 = 0; bus.req1 = 1; bus.addr1 = 32'h0C;
      @(negedge clock);
      chk("alt3_gnt", 32'({bus.gnt0, bus.gnt1}), 32'b01);
      chk("rd0_rvalid", 32'(bus.rvalid0), 1);
      chk("rd0_rdata", bus.rdata0, 32'h0000_00FF);
      chk("alt3_hold", 32'(u_dut.hold_cnt), 0);
      tick(); bus.req1 = 0;
      @(negedge clock);
      chk("alt4_rdata1", bus.rdata1, 32'hA5);
      chk("alt4_rvalid0", 32'(bus.rvalid0), 0);
      chk("alt4_hold", 32'(u_dut.hold_cnt), 0);

      // write then read-back on consecutive grants
      tick(); bus.req0 = 1; bus.we0 = 1; bus.addr0 = 32'h10; bus.wd0 = 32'h1234_5678;
      @(negedge clock);
      chk("wr_gnt0", 32'(bus.gnt0), 1);
      chk("wr_we", 32'(bus.mem_we), 1);
      chk("wr_addr", bus.mem_addr, 32'h10);
      chk("wr_wd", bus.mem_wd, 32'h1234_5678);
      tick(); bus.we0 = 0;
      @(negedge clock);
      chk("rd_we", 32'(bus.mem_we), 0);
      chk("wr_no_rvalid", 32'(bus.rvalid0), 0);
      chk("rdata0_hold", bus.rdata0, 32'hFF);
      chk("ram_commit", ram[4], 32'h1234_5678);
      tick(); bus.req0 = 0;
      @(negedge clock);
      chk("raw_rvalid", 32'(bus.rvalid0), 1);
      chk("raw_rdata", bus.rdata0, 32'h1234_5678);

      // req1 write so that requester 0 wins the next contention from IDLE
      tick(); bus.req1 = 1; bus.we1 = 1; bus.addr1 = 32'h20; bus.wd1 = 32'hCAFE;
      @(negedge clock);
      chk("wr1_gnt", 32'({bus.gnt0, bus.gnt1}), 32'b01);
      chk("wr1_wd", bus.mem_wd, 32'hCAFE);
      tick(); bus.req1 = 0; bus.we1 = 0;
`ifdef DMEM_ARB_STATS_EN
      stat_clr = 1;
`endif
      @(negedge clock);
      chk("wr1_rvalid", 32'(bus.rvalid1), 0);
      chk("ram_commit1", ram[8], 32'hCAFE);

      tick();
`ifdef DMEM_ARB_STATS_EN
      stat_clr = 0;
`endif
      bus.req0 = 1; bus.req1 = 1; bus.addr0 = 32'h08; bus.addr1 = 32'h0C;
      for (int k = 0; k < 9; k++) begin
         @(negedge clock);
         chk($sformatf("cont%0d_gnt", k), 32'({bus.gnt0, bus.gnt1}),
             CONT_GNT0[k] ? 32'b10 : 32'b01);
         chk($sformatf("cont%0d_hold", k), 32'(u_dut.hold_cnt), 32'(hold_exp[k]));
         tick();
      end
      bus.req0 = 0; bus.req1 = 0;
      @(negedge clock);
`ifdef DMEM_ARB_STATS_EN
      chk("stat_gnt0", 32'(stat_gnt0), 5);
      chk("stat_gnt1", 32'(stat_gnt1), 4);
      chk("stat_conflict", 32'(stat_conflict), 9);
      tick(); bus.req0 = 1; stat_clr = 1;
      tick(); bus.req0 = 0; stat_clr = 0;
      @(negedge clock);
      chk("clr_gnt0", 32'(stat_gnt0), 0);
      chk("clr_gnt1", 32'(stat_gnt1), 0);
      chk("clr_conflict", 32'(stat_conflict), 0);
`endif

      // reset in the middle of a req1 read burst
      tick(); bus.req1 = 1; bus.we1 = 0; bus.addr1 = 32'h08;
      @(negedge clock);
      chk("rr_gnt1", 32'(bus.gnt1), 1);
      tick();
      #1;
      chk("rr_rvalid1_pre", 32'(bus.rvalid1), 1);
      reset = 1'b1;
      #1;
      chk("rr_rvalid1_rst", 32'(bus.rvalid1), 0);
      chk("rr_rdata1_rst", bus.rdata1, 0);
      reset = 1'b0;
      bus.req0 = 1; bus.we0 = 0;
      #1;
      chk("post_rst_gnt", 32'({bus.gnt0, bus.gnt1}), 32'b10);
      tick(); bus.req0 = 0; bus.req1 = 0;
      @(negedge clock);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   always @(negedge clock) begin
      if (!reset && bus.gnt0 && bus.gnt1) begin
         n_checks++;
         n_errors++;
         $display("FAIL onehot: got gnt0=1 gnt1=1 expected at most one");
      end
   end

endmodule
